// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Drives pipeline register enables, the IF/ID flush and the ID/EX bubble from hazard inputs.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic [4:0]       IFID_Rs1_i,
  input  logic [4:0]       IFID_Rs2_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             PC_we_o,
  output logic             IFID_we_o,
  output logic             IFID_flush_o,
  output logic             IDEX_we_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_we_o,
  output logic             MEMWB_we_o,
  output logic [2:0]       state_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  localparam logic [15:0]      TIMEOUT_C    = 16'(MEM_TIMEOUT);
  localparam logic [3:0]       DRAIN_LAST_C = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_MAX_C  = {CNT_W{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [15:0]      wait_cnt_r, wait_cnt_nxt_s;
  logic [16:0]      wait_inc_s;
  logic [3:0]       drain_cnt_r, drain_cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             err_r;
  logic             mem_stall_s, load_use_s, stall_event_s;
  logic             pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s, idex_bubble_s;
  logic             exmem_we_s, memwb_we_s, done_s;

  assign mem_stall_s = dmem_req_i && !dmem_ready_i;
  // x0 is hardwired to zero, so a load targeting it can never feed a dependent read
  assign load_use_s  = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                       ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));
  assign wait_inc_s  = {1'b0, wait_cnt_r} + 17'd1;
  assign stall_event_s = ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) && !pc_we_s;

  // Next-state, counter and enable decode
  always_comb begin
    state_nxt_s     = state_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    pc_we_s         = 1'b0;
    ifid_we_s       = 1'b0;
    ifid_flush_s    = 1'b0;
    idex_we_s       = 1'b0;
    idex_bubble_s   = 1'b0;
    exmem_we_s      = 1'b0;
    memwb_we_s      = 1'b0;
    done_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        if ((state_r == ST_RUN) && mem_stall_s) begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = 16'd1;
        end else if ((state_r == ST_MEM_WAIT) && !dmem_ready_i) begin
          wait_cnt_nxt_s = wait_inc_s[15:0];
          if (wait_inc_s >= {1'b0, TIMEOUT_C}) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_MEM_WAIT;
          end
        end else begin
          // Normal issue, also used for the MEM_WAIT release cycle
          wait_cnt_nxt_s = 16'd0;
          pc_we_s        = !load_use_s;
          ifid_we_s      = !load_use_s;
          idex_bubble_s  = load_use_s;
          ifid_flush_s   = !load_use_s && branch_taken_i;
          idex_we_s      = 1'b1;
          exmem_we_s     = 1'b1;
          memwb_we_s     = 1'b1;
          if (halt_i) begin
            state_nxt_s     = ST_DRAIN;
            drain_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        ifid_flush_s = 1'b1;
        if (mem_stall_s) begin
          drain_cnt_nxt_s = drain_cnt_r;
        end else begin
          idex_we_s  = 1'b1;
          exmem_we_s = 1'b1;
          memwb_we_s = 1'b1;
          if (drain_cnt_r >= DRAIN_LAST_C) begin
            done_s          = 1'b1;
            drain_cnt_nxt_s = 4'd0;
            state_nxt_s     = ST_IDLE;
          end else begin
            drain_cnt_nxt_s = drain_cnt_r + 4'd1;
          end
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 16'd0;
      drain_cnt_r <= 4'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      err_r       <= err_r || (state_nxt_s == ST_ERROR);
    end
  end

  // Saturating stall performance counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_event_s && (stall_cnt_r != STALL_MAX_C)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign PC_we_o       = pc_we_s;
  assign IFID_we_o     = ifid_we_s;
  assign IFID_flush_o  = ifid_flush_s;
  assign IDEX_we_o     = idex_we_s;
  assign IDEX_bubble_o = idex_bubble_s;
  assign EXMEM_we_o    = exmem_we_s;
  assign MEMWB_we_o    = memwb_we_s;
  assign state_o       = state_r;
  assign done_o        = done_s;
  assign err_o         = err_r;
  assign stall_cnt_o   = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the sequencer rules.
module tb_pipeline_ctrl;

  localparam int T_OUT  = 8;
  localparam int N_DRN  = 4;
  localparam int CW     = 5;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, halt, memread, br, req, ready;
  logic [4:0]    rd, rs1, rs2;
  logic          pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
  logic [2:0]    state;
  logic          done, err;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: mode, stalled-cycle run length, drain progress, stall total
  int m_state, m_wait, m_drain, m_stall;
  logic [16:0] exp_vec, act_vec;

  pipeline_ctrl #(.MEM_TIMEOUT(T_OUT), .DRAIN_CYCLES(N_DRN), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .halt_i(halt),
    .IDEX_MemRead_i(memread), .IDEX_Rd_i(rd), .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
    .branch_taken_i(br), .dmem_req_i(req), .dmem_ready_i(ready),
    .PC_we_o(pc_we), .IFID_we_o(ifid_we), .IFID_flush_o(ifid_flush),
    .IDEX_we_o(idex_we), .IDEX_bubble_o(idex_bubble), .EXMEM_we_o(exmem_we),
    .MEMWB_we_o(memwb_we), .state_o(state), .done_o(done), .err_o(err),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pack_dut();
    return {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we,
            done, err, state, stall_cnt};
  endfunction

  task automatic clear_inputs();
    start = 1'b0; halt = 1'b0; memread = 1'b0; br = 1'b0; req = 1'b0; ready = 1'b0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  // Samples DUT mid-cycle, computes model expectation, then advances the model at the edge.
  task automatic run_cycle();
    bit lu, wt, pc, ifd, fl, ide, bub, exm, mwb, dn;
    int nxt, nwait, ndrain;
    @(negedge clk);
    lu = memread && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    {pc, ifd, fl, ide, bub, exm, mwb, dn} = 8'd0;
    nxt = m_state; nwait = m_wait; ndrain = m_drain;
    if (m_state == 0) begin
      nxt = start ? 1 : 0;
    end else if (m_state == 1 || m_state == 2) begin
      wt = (m_state == 1) ? (req && !ready) : !ready;
      if (wt) begin
        nwait = (m_state == 1) ? 1 : m_wait + 1;
        nxt = (nwait >= T_OUT) ? 4 : 2;
      end else begin
        nwait = 0;
        pc = !lu; ifd = !lu; bub = lu; fl = !lu && br;
        ide = 1; exm = 1; mwb = 1;
        nxt = halt ? 3 : 1;
        if (halt) ndrain = 0;
      end
    end else if (m_state == 3) begin
      fl = 1;
      if (!(req && !ready)) begin
        ide = 1; exm = 1; mwb = 1;
        ndrain = m_drain + 1;
        if (ndrain == N_DRN) begin dn = 1; nxt = 0; ndrain = 0; end
      end
    end
    exp_vec = {pc, ifd, fl, ide, bub, exm, mwb, dn, (m_state == 4), 3'(m_state), 5'(m_stall)};
    act_vec = pack_dut();
    @(posedge clk);
    if ((m_state == 1 || m_state == 2) && !pc && m_stall < SATMAX) m_stall++;
    m_state = nxt; m_wait = nwait; m_drain = ndrain;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    n_tests++;
    if (pack_dut() !== 17'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", pack_dut(), 17'd0);
    end
    m_state = 0; m_wait = 0; m_drain = 0; m_stall = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec) begin
      n_fail++; $display("FAIL idle_hold: got %h want %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    run_cycle();
    start = 1'b0;
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[7:5] !== 3'd1 || act_vec[16:10] !== 7'b1101011 ||
        act_vec[4:0] !== 5'd0) begin
      n_fail++; $display("FAIL start_run: got %h want %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] s0;
    memread = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    run_cycle();
    s0 = act_vec[4:0];
    n_tests++;
    if (act_vec !== exp_vec || act_vec[16:10] !== 7'b0001111) begin
      n_fail++; $display("FAIL load_use_stall: got %h want %h", act_vec, exp_vec);
    end
    clear_inputs();
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[16:10] !== 7'b1101011 || act_vec[4:0] !== s0 + 5'd1) begin
      n_fail++; $display("FAIL load_use_release: got %h want %h", act_vec, exp_vec);
    end
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[16:10] !== 7'b1101011) begin
      n_fail++; $display("FAIL load_use_x0: got %h want %h", act_vec, exp_vec);
    end
    clear_inputs();
  endtask

  task automatic test_branch_vs_load_use();
    br = 1'b1;
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[16:10] !== 7'b1111011) begin
      n_fail++; $display("FAIL branch_flush: got %h want %h", act_vec, exp_vec);
    end
    memread = 1'b1; rd = 5'd9; rs1 = 5'd9; rs2 = 5'd1;
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[16:10] !== 7'b0001111) begin
      n_fail++; $display("FAIL branch_vs_load_use: got %h want %h", act_vec, exp_vec);
    end
    clear_inputs();
    run_cycle();
  endtask

  task automatic test_mem_wait();
    logic [4:0] s0;
    int zero_cycles = 0;
    s0 = stall_cnt;
    req = 1'b1; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      if (act_vec[16:10] === 7'b0000000) zero_cycles++;
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL mem_wait_cycle%0d: got %h want %h", i, act_vec, exp_vec);
      end
    end
    ready = 1'b1;
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[16:10] !== 7'b1101011 || act_vec[7:5] !== 3'd2 ||
        zero_cycles != 3) begin
      n_fail++; $display("FAIL mem_wait_release: got %h want %h zeros %0d", act_vec, exp_vec, zero_cycles);
    end
    clear_inputs();
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[7:5] !== 3'd1 || act_vec[4:0] !== s0 + 5'd3) begin
      n_fail++; $display("FAIL mem_wait_back_to_run: got %h want %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_halt_drain();
    int drain_cycles = 0, dones = 0, bad_flush = 0, guard = 0;
    halt = 1'b1;
    run_cycle();
    halt = 1'b0;
    while (state == 3'd3 && guard < 20) begin
      req = (drain_cycles == 2); ready = 1'b0;
      run_cycle();
      guard++;
      drain_cycles++;
      if (act_vec[9]) dones++;
      if (!act_vec[14]) bad_flush++;
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL drain_cycle%0d: got %h want %h", drain_cycles, act_vec, exp_vec);
      end
    end
    clear_inputs();
    n_tests++;
    if (drain_cycles != 5 || dones != 1 || bad_flush != 0 || state !== 3'd0) begin
      n_fail++; $display("FAIL halt_drain: got cycles %0d dones %0d state %0d want 5 1 0",
                         drain_cycles, dones, state);
    end
  endtask

  task automatic test_timeout();
    int zero_cycles = 0, guard = 0;
    start = 1'b1; run_cycle(); start = 1'b0;
    req = 1'b1; ready = 1'b0;
    while (state !== 3'd4 && guard < 30) begin
      run_cycle();
      guard++;
      if (act_vec[16:10] === 7'b0000000) zero_cycles++;
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++; $display("FAIL timeout_cycle%0d: got %h want %h", guard, act_vec, exp_vec);
      end
    end
    n_tests++;
    if (zero_cycles != T_OUT || state !== 3'd4 || err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_entry: got waits %0d state %0d want %0d 4", zero_cycles, state, T_OUT);
    end
    req = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[8] !== 1'b1 || act_vec[7:5] !== 3'd4) begin
      n_fail++; $display("FAIL error_sticky: got %h want %h", act_vec, exp_vec);
    end
    do_reset();
  endtask

  task automatic test_saturation();
    start = 1'b1; run_cycle(); start = 1'b0;
    memread = 1'b1; rd = 5'd7; rs1 = 5'd7;
    for (int i = 0; i < SATMAX + 8; i++) run_cycle();
    clear_inputs();
    run_cycle();
    n_tests++;
    if (act_vec !== exp_vec || act_vec[4:0] !== 5'(SATMAX)) begin
      n_fail++; $display("FAIL stall_saturate: got %h want %h", act_vec, exp_vec);
    end
    do_reset();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_state == 4 && $urandom_range(0, 3) == 0) do_reset();
      start   = ($urandom_range(0, 3) == 0);
      halt    = ($urandom_range(0, 19) == 0);
      memread = $urandom_range(0, 1);
      rd      = 5'($urandom_range(0, 5));
      rs1     = 5'($urandom_range(0, 5));
      rs2     = 5'($urandom_range(0, 5));
      br      = ($urandom_range(0, 3) == 0);
      req     = ($urandom_range(0, 2) == 0);
      ready   = ($urandom_range(0, 3) != 0);
      run_cycle();
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL random_cycle%0d: got %h want %h", i, act_vec, exp_vec);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    m_state = 0; m_wait = 0; m_drain = 0; m_stall = 0;
    #3;
    test_reset();
    test_start();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_halt_drain();
    test_timeout();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, the IF/ID flush, and the ID/EX bubble (zeroes RegWrite, MemToReg, MemRead, MemWrite, ALUSrc and ALUOp into ID/EX).
- Resolves load-use hazards, taken-branch flushes, multi-cycle data-memory waits with timeout, and a halt/drain sequence.

Parameters:
MEM_TIMEOUT, 255, max cycles in MEM_WAIT before ERROR (1..2^16-1)
DRAIN_CYCLES, 4, cycles of drain after halt before IDLE (1..15)
CNT_W, 16, width of the stall performance counter

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset; asynchronous, active-low
start_i  in  1  leave IDLE and begin execution
halt_i  in  1  request pipeline drain
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_Rd_i  in  5  destination register of instruction in EX
IFID_Rs1_i  in  5  rs1 of instruction in ID
IFID_Rs2_i  in  5  rs2 of instruction in ID
branch_taken_i  in  1  branch in ID resolved taken
dmem_req_i  in  1  MEM stage issuing a data-memory access
dmem_ready_i  in  1  data memory completes the access this cycle
PC_we_o  out  1  PC update enable
IFID_we_o  out  1  IF/ID write enable
IFID_flush_o  out  1  load NOP into IF/ID
IDEX_we_o  out  1  ID/EX write enable
IDEX_bubble_o  out  1  zero control fields into ID/EX
EXMEM_we_o  out  1  EX/MEM write enable
MEMWB_we_o  out  1  MEM/WB write enable
state_o  out  3  IDLE=0, RUN=1, MEM_WAIT=2, DRAIN=3, ERROR=4
done_o  out  1  one-cycle pulse when DRAIN completes
err_o  out  1  sticky memory-timeout flag
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n_i=0): state IDLE. Wait and drain counters 0, stall_cnt_o=0, err_o=0, done_o=0. All enables, flush and bubble are 0. Reset mid-operation aborts any state immediately.
- Outputs are combinational from the registered state and the current inputs. State and counters are registered.
- IDLE: all enables 0. start_i=1 -> RUN next cycle.
- RUN priority, highest first:
  1. Memory wait: dmem_req_i=1 and dmem_ready_i=0 -> all five we_o=0, no flush, no bubble. Next state MEM_WAIT; wait counter loads 1.
  2. Load-use: IDEX_MemRead_i=1, IDEX_Rd_i!=0, and IDEX_Rd_i equals IFID_Rs1_i or IFID_Rs2_i -> PC_we_o=0, IFID_we_o=0, IDEX_bubble_o=1; IDEX/EXMEM/MEMWB we_o=1. Stall lasts exactly one cycle.
  3. Branch: branch_taken_i=1 -> all we_o=1, IFID_flush_o=1.
  4. Halt: halt_i=1 -> all we_o=1, next state DRAIN with drain counter=0. If halt_i coincides with load-use or branch, those outputs apply this cycle and DRAIN is still entered.
  5. Otherwise all we_o=1.
- MEM_WAIT:
  - dmem_ready_i=0: all we_o=0; wait counter increments. When the counter reaches MEM_TIMEOUT -> ERROR.
  - dmem_ready_i=1: release cycle. Evaluate RUN rules 2-5 with their outputs and transitions; otherwise return to RUN.
- DRAIN:
  - PC_we_o=0, IFID_flush_o=1; IDEX, EXMEM, MEMWB we_o=1.
  - A memory wait (dmem_req_i=1, dmem_ready_i=0) freezes all we_o=0 and holds the drain counter.
  - Otherwise the counter increments. After DRAIN_CYCLES advancing cycles: done_o=1 for one cycle, next state IDLE.
  - halt_i, start_i and branch_taken_i are ignored in DRAIN.
- ERROR: all enables 0, err_o=1 sticky. Exit only via reset.
- stall_cnt_o increments by 1 in any RUN or MEM_WAIT cycle where PC_we_o=0. Saturates at all-ones.
- Register x0 never causes a load-use stall.

Test Plan:
- Reset, start_i pulse -> state_o 0->1; all we_o=1; stall_cnt_o=0.
- Load to x5 in EX, ID reads rs2=x5 -> one cycle PC_we_o=0, IFID_we_o=0, IDEX_bubble_o=1, then normal; stall_cnt_o=1. Same case with Rd=x0 -> no stall.
- dmem_req_i=1, ready arrives after 3 cycles -> 3 cycles all we_o=0 in MEM_WAIT, release cycle all we_o=1, state back to RUN; stall_cnt_o=3.
- MEM_TIMEOUT=8, ready never asserted -> state_o=4 after 8 wait cycles, err_o=1 and held; rst_n_i low clears it.
- branch_taken_i and load-use in the same cycle -> load-use wins: bubble=1, IFID_flush_o=0.
- halt_i in RUN, DRAIN_CYCLES=4, one memory wait mid-drain -> 5 DRAIN cycles, IFID_flush_o=1 throughout, done_o pulse, state_o=0.
